tmds_encoder_bank: RTL and testbench

//  Parametrised N-channel TMDS symbol generator in the pixel-clock domain; successor to the fixed 3-ch DVI path.
//  Per cycle, every channel emits one 10-bit symbol selected by mode: control, video (8b/10b, DC-balanced),

---
 rtl/tmds_pkg.sv | 36 +++
 rtl/tmds_encoder_bank_if.sv | 24 ++
 rtl/tmds_channel_encoder.sv | 110 +++++++++++
 rtl/tmds_encoder_bank.sv | 39 +++
 tb/tb_tmds_encoder_bank.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS symbol tables, channel-mode encoding and the byte popcount helper
// used by every channel encoder.
package tmds_pkg;

    typedef enum logic [1:0] {
        MODE_CTRL   = 2'd0,
        MODE_VIDEO  = 2'd1,
        MODE_GUARD  = 2'd2,
        MODE_TERC4  = 2'd3
    } tmds_mode_t;

    localparam logic [9:0] CTRL_CODE [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    localparam logic [9:0] TERC4_CODE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    localparam logic [9:0] GUARD_CODE_A = 10'b1011001100;
    localparam logic [9:0] GUARD_CODE_B = 10'b0100110011;
    localparam logic [9:0] CLK_PATTERN  = 10'b0000011111;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_encoder_bank_if.sv
// Symbol-bank bus: per-cycle mode/payload towards the encoders, symbols and
// valid flag back towards the serializers.
interface tmds_encoder_bank_if #(parameter int NUM_CH = 3);

    logic                   i_en;
    logic [1:0]             i_mode;
    logic [NUM_CH*8-1:0]    i_data;
    logic [NUM_CH*2-1:0]    i_ctrl;
    logic [NUM_CH*4-1:0]    i_aux;
    logic [NUM_CH*10-1:0]   o_tmds;
    logic [9:0]             o_tmds_clk;
    logic                   o_valid;

    modport master (
        output i_en, i_mode, i_data, i_ctrl, i_aux,
        input  o_tmds, o_tmds_clk, o_valid
    );

    modport slave (
        input  i_en, i_mode, i_data, i_ctrl, i_aux,
        output o_tmds, o_tmds_clk, o_valid
    );

endinterface

// File: rtl/tmds_channel_encoder.sv
// One TMDS lane: stage 1 minimises transitions and counts ones, stage 2 picks
// the symbol for the current mode and tracks running disparity.
module tmds_channel_encoder import tmds_pkg::*; #(
    parameter int CH_IDX = 0
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [7:0]  data,
    input  logic [1:0]  ctrl,
    input  logic [3:0]  aux,
    output logic [9:0]  tmds
);

    localparam logic [9:0] GUARD_SYM = (CH_IDX % 3 == 1) ? GUARD_CODE_B : GUARD_CODE_A;

    logic [3:0]         n1_data;
    logic               use_xnor;
    logic [8:0]         q_m_next;

    tmds_mode_t         mode_reg;
    logic [8:0]         q_m_reg;
    logic [3:0]         n1_reg;
    logic [1:0]         ctrl_reg;
    logic [3:0]         aux_reg;

    logic [9:0]         tmds_reg;
    logic [9:0]         tmds_next;
    logic signed [4:0]  cnt_reg;
    logic signed [4:0]  cnt_next;

    logic signed [5:0]  diff;
    logic signed [5:0]  cnt_ext;
    logic signed [5:0]  video_cnt;
    logic [9:0]         video_sym;

    always_comb begin
        n1_data  = popcount8(data);
        use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data[0]);
        q_m_next = '0;
        q_m_next[0] = data[0];
        for (int i = 1; i < 8; i++) begin
            q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ data[i]) : (q_m_next[i-1] ^ data[i]);
        end
        q_m_next[8] = ~use_xnor;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            mode_reg <= MODE_CTRL;
            q_m_reg  <= '0;
            n1_reg   <= '0;
            ctrl_reg <= '0;
            aux_reg  <= '0;
        end else if (en) begin
            mode_reg <= tmds_mode_t'(mode);
            q_m_reg  <= q_m_next;
            n1_reg   <= popcount8(q_m_next[7:0]);
            ctrl_reg <= ctrl;
            aux_reg  <= aux;
        end
    end

    // diff is N1-N0 of q_m[7:0]; all disparity math is done at 6 bits, the
    // result always fits back into the 5-bit counter.
    always_comb begin
        diff      = $signed({1'b0, n1_reg, 1'b0}) - 6'sd8;
        cnt_ext   = {cnt_reg[4], cnt_reg};
        video_sym = '0;
        video_cnt = '0;
        if ((cnt_reg == 5'sd0) || (n1_reg == 4'd4)) begin
            video_sym = {~q_m_reg[8], q_m_reg[8], q_m_reg[8] ? q_m_reg[7:0] : ~q_m_reg[7:0]};
            video_cnt = q_m_reg[8] ? (cnt_ext + diff) : (cnt_ext - diff);
        end else if (((cnt_reg > 5'sd0) && (n1_reg > 4'd4)) ||
                     ((cnt_reg < 5'sd0) && (n1_reg < 4'd4))) begin
            video_sym = {1'b1, q_m_reg[8], ~q_m_reg[7:0]};
            video_cnt = cnt_ext + (q_m_reg[8] ? 6'sd2 : 6'sd0) - diff;
        end else begin
            video_sym = {1'b0, q_m_reg[8], q_m_reg[7:0]};
            video_cnt = cnt_ext - (q_m_reg[8] ? 6'sd0 : 6'sd2) + diff;
        end

        tmds_next = CTRL_CODE[ctrl_reg];
        cnt_next  = 5'sd0;
        case (mode_reg)
            MODE_CTRL:  tmds_next = CTRL_CODE[ctrl_reg];
            MODE_VIDEO: begin
                tmds_next = video_sym;
                cnt_next  = video_cnt[4:0];
            end
            MODE_GUARD: tmds_next = GUARD_SYM;
            MODE_TERC4: tmds_next = TERC4_CODE[aux_reg];
            default:    tmds_next = CTRL_CODE[0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            tmds_reg <= CTRL_CODE[0];
            cnt_reg  <= 5'sd0;
        end else if (en) begin
            tmds_reg <= tmds_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign tmds = tmds_reg;

endmodule

// File: rtl/tmds_encoder_bank.sv
// N-lane TMDS symbol bank: one encoder per data lane plus the fixed clock-lane
// pattern; a two-deep fill register marks when the pipeline holds real symbols.
module tmds_encoder_bank import tmds_pkg::*; #(
    parameter int NUM_CH = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    tmds_encoder_bank_if.slave   bus
);

    logic [NUM_CH*10-1:0] tmds_bus;
    logic [1:0]           valid_reg;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        tmds_channel_encoder #(.CH_IDX(gi)) u_ch (
            .clk  (i_clk),
            .srst (i_rst),
            .en   (bus.i_en),
            .mode (bus.i_mode),
            .data (bus.i_data[8*gi +: 8]),
            .ctrl (bus.i_ctrl[2*gi +: 2]),
            .aux  (bus.i_aux[4*gi +: 4]),
            .tmds (tmds_bus[10*gi +: 10])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_reg <= 2'b00;
        end else if (bus.i_en) begin
            valid_reg <= {valid_reg[0], 1'b1};
        end
    end

    assign bus.o_tmds     = tmds_bus;
    assign bus.o_tmds_clk = CLK_PATTERN;
    assign bus.o_valid    = valid_reg[1];

endmodule

// File: tb/tb_tmds_encoder_bank.sv
// Randomised bench for the TMDS bank: an arithmetic reference model fills a
// scoreboard at stimulus time and an independent monitor checks every symbol.
module tb_tmds_encoder_bank;

    localparam int NUM_CH = 5;
    localparam int W      = NUM_CH * 10;

    localparam logic [9:0] CTRL_TAB [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };
    localparam logic [9:0] TERC_TAB [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
    localparam logic [9:0] GUARD_A = 10'b1011001100;
    localparam logic [9:0] GUARD_B = 10'b0100110011;

    typedef struct {
        logic [W-1:0]          sym;
        bit                    video;
        logic [NUM_CH*8-1:0]   data;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tmds_encoder_bank_if #(.NUM_CH(NUM_CH)) bus ();

    tmds_encoder_bank #(.NUM_CH(NUM_CH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    item_t sb[$];
    int    model_cnt [NUM_CH];
    int    passed = 0;
    int    total  = 0;
    bit    fired  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // q_m bit i is the parity of d[0..i]; the XNOR variant flips every odd bit.
    function automatic logic [9:0] model_video(input int ch, input logic [7:0] d);
        int         n1;
        int         disp;
        bit         inv_chain;
        bit         q8;
        logic [7:0] q;
        logic [7:0] m;
        logic [9:0] s;
        n1        = $countones(d);
        inv_chain = (n1 > 4) || (n1 == 4 && !d[0]);
        q8        = !inv_chain;
        for (int i = 0; i < 8; i++) begin
            m    = 8'((1 << (i + 1)) - 1);
            q[i] = (($countones(d & m) % 2) == 1) ^ (inv_chain && (i % 2 == 1));
        end
        disp = 2 * $countones(q) - 8;
        if (model_cnt[ch] == 0 || disp == 0) begin
            if (q8) begin
                s = {2'b01, q};
                model_cnt[ch] += disp;
            end else begin
                s = {2'b10, ~q};
                model_cnt[ch] -= disp;
            end
        end else if ((model_cnt[ch] > 0 && disp > 0) || (model_cnt[ch] < 0 && disp < 0)) begin
            s = {1'b1, q8, ~q};
            model_cnt[ch] += (q8 ? 2 : 0) - disp;
        end else begin
            s = {1'b0, q8, q};
            model_cnt[ch] += disp - (q8 ? 0 : 2);
        end
        return s;
    endfunction

    function automatic logic [9:0] model_sym(input int ch, input int mode, input logic [7:0] d,
                                             input logic [1:0] c, input logic [3:0] a);
        logic [9:0] s;
        case (mode)
            1:       s = model_video(ch, d);
            2:       s = (ch % 3 == 1) ? GUARD_B : GUARD_A;
            3:       s = TERC_TAB[a];
            default: s = CTRL_TAB[c];
        endcase
        if (mode != 1) model_cnt[ch] = 0;
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int mode, input logic [NUM_CH*8-1:0] d,
                         input logic [NUM_CH*2-1:0] c, input logic [NUM_CH*4-1:0] a);
        item_t it;
        bus.i_en   = 1'b1;
        bus.i_mode = 2'(mode);
        bus.i_data = d;
        bus.i_ctrl = c;
        bus.i_aux  = a;
        it.video   = (mode == 1);
        it.data    = d;
        it.sym     = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            it.sym[10*ch +: 10] = model_sym(ch, mode, d[8*ch +: 8], c[2*ch +: 2], a[4*ch +: 4]);
        end
        sb.push_back(it);
        step();
    endtask

    task automatic drive_rand(input int mode);
        drive(mode, 40'({$urandom(), $urandom()}), 10'($urandom()), 20'($urandom()));
    endtask

    task automatic idle_rand();
        bus.i_en   = 1'b0;
        bus.i_mode = 2'($urandom());
        bus.i_data = 40'({$urandom(), $urandom()});
        bus.i_ctrl = 10'($urandom());
        bus.i_aux  = 20'($urandom());
        step();
    endtask

    task automatic reset_dut();
        rst        = 1'b1;
        bus.i_en   = 1'($urandom());
        bus.i_mode = 2'($urandom());
        bus.i_data = 40'({$urandom(), $urandom()});
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_tmds", 64'(bus.o_tmds), 64'({NUM_CH{10'b1101010100}}));
            check("reset_valid", 64'(bus.o_valid), 64'd0);
            check("reset_tmds_clk", 64'(bus.o_tmds_clk), 64'(10'b0000011111));
        end
        sb.delete();
        for (int ch = 0; ch < NUM_CH; ch++) model_cnt[ch] = 0;
        rst = 1'b0;
    endtask

    // Monitor: a new symbol is presented after every enabled, non-reset edge
    // once the valid flag is up.
    always @(posedge clk) fired = bus.i_en && !rst;

    always @(negedge clk) begin
        item_t       it;
        logic [63:0] dec;
        logic [7:0]  dv;
        logic [9:0]  s;
        if (fired && bus.o_valid) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL scoreboard_underflow: got symbol %h expected none", bus.o_tmds);
            end else begin
                it = sb.pop_front();
                check("symbol", 64'(bus.o_tmds), 64'(it.sym));
                check("tmds_clk", 64'(bus.o_tmds_clk), 64'(10'b0000011111));
                if (it.video) begin
                    dec = '0;
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        s = bus.o_tmds[10*ch +: 10];
                        dv = s[9] ? ~s[7:0] : s[7:0];
                        dec[8*ch] = dv[0];
                        for (int i = 1; i < 8; i++) begin
                            dec[8*ch + i] = s[8] ? (dv[i] ^ dv[i-1]) : ~(dv[i] ^ dv[i-1]);
                        end
                    end
                    check("video_decode", dec, 64'(it.data));
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0]  frozen;
        logic [W-1:0]  guard_exp;
        bus.i_en   = 1'b0;
        bus.i_mode = 2'd0;
        bus.i_data = '0;
        bus.i_ctrl = '0;
        bus.i_aux  = '0;

        // Reset, then CTRL 00: valid only after the second enabled cycle.
        reset_dut();
        drive(0, '0, '0, '0);
        check("valid_after_1", 64'(bus.o_valid), 64'd0);
        drive(0, '0, '0, '0);
        check("valid_after_2", 64'(bus.o_valid), 64'd1);
        check("ctrl00", 64'(bus.o_tmds), 64'({NUM_CH{10'b1101010100}}));

        // Two zero bytes from balanced state.
        reset_dut();
        drive(1, '0, '0, '0);
        drive(1, '0, '0, '0);
        check("video00_first", 64'(bus.o_tmds), 64'({NUM_CH{10'b0100000000}}));
        drive(0, '0, '0, '0);
        check("video00_second", 64'(bus.o_tmds), 64'({NUM_CH{10'b1111111111}}));

        // A single CTRL symbol rebalances the disparity counters.
        for (int i = 0; i < 16; i++) drive_rand(1);
        drive(0, '0, '0, '0);
        drive(1, '0, '0, '0);
        drive(0, '0, '0, '0);
        check("video00_after_ctrl", 64'(bus.o_tmds), 64'({NUM_CH{10'b0100000000}}));

        for (int i = 0; i < 10000; i++) drive_rand(1);

        // Guard band and TERC4 nibble C.
        for (int ch = 0; ch < NUM_CH; ch++) guard_exp[10*ch +: 10] = (ch % 3 == 1) ? GUARD_B : GUARD_A;
        drive_rand(2);
        drive(3, 40'({$urandom(), $urandom()}), 10'($urandom()), {NUM_CH{4'hC}});
        check("guard", 64'(bus.o_tmds), 64'(guard_exp));
        drive_rand(0);
        check("terc4_c", 64'(bus.o_tmds), 64'({NUM_CH{10'b1010001110}}));

        // Stall mid-video: outputs hold, stream resumes where it left off.
        for (int i = 0; i < 10; i++) drive_rand(1);
        frozen = bus.o_tmds;
        for (int i = 0; i < 4; i++) begin
            idle_rand();
            check("stall_tmds", 64'(bus.o_tmds), 64'(frozen));
            check("stall_valid", 64'(bus.o_valid), 64'd1);
        end
        for (int i = 0; i < 10; i++) drive_rand(1);

        // Per-cycle mode rotation.
        for (int i = 0; i < 400; i++) drive_rand(i % 4);

        // Random modes, random enable, occasional mid-stream reset.
        for (int i = 0; i < 2000; i++) begin
            if (i % 700 == 350) reset_dut();
            if ($urandom_range(0, 4) == 0) idle_rand();
            else drive_rand(int'($urandom_range(0, 3)));
        end

        // The last accepted input is still in stage 1 and never emerges.
        bus.i_en = 1'b0;
        repeat (3) step();
        check("scoreboard_remaining", 64'(sb.size()), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
